// File: rtl/iob_rom_arb.vh
// Shared localparams for iob_rom_arb. Included inside the module body, after
// the parameter list, so it can see OUT_REG and N_PORTS.
//   LAT   : cycles from accept edge to response (1, or 2 with OUT_REG=1)
//   PTR_W : width of a port index (at least 1 so N_PORTS=1 still has a field)
localparam int LAT   = 1 + OUT_REG;
localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

// File: rtl/iob_rr_arb.sv
// iob_rr_arb: round-robin arbiter with a rotating priority pointer.
// Priority descends from the pointer p, wrapping mod N. After a grant to port g
// the pointer moves to (g+1) mod N; it holds when nothing is granted.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (pointer -> 0)
//   req   : per-port request
//   gnt   : one-hot grant, combinational from req and the pointer
module iob_rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic          found;

  // Scan offsets k = 0..N-1 from the pointer; the first requesting port seen
  // wins. With N=1 this degenerates to gnt = req and the pointer stays at 0.
  always_comb begin
    gnt      = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (((int'(ptr_reg) + k) % N) == j)) begin
          gnt[j]   = 1'b1;
          found    = 1'b1;
          ptr_next = PW'((j + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/iob_rom_arb.sv
// iob_rom_arb: single-read-port ROM shared by N_PORTS requesters through a
// round-robin arbiter. One request is accepted per cycle; its data returns to
// the granted port LAT cycles later as a one-cycle rsp_valid pulse. Each port
// keeps its last read data on rsp_data until its next response.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req_valid : per-port read request
//   req_addr  : per-port address, port i at [i*ADDR_W +: ADDR_W]
//   req_ready : per-port grant (combinational)
//   rsp_valid : per-port response pulse
//   rsp_data  : per-port read data, port i at [i*DATA_W +: DATA_W]
module iob_rom_arb #(
  parameter string HEXFILE = "none",
  parameter int    DATA_W  = 32,
  parameter int    ADDR_W  = 11,
  parameter int    N_PORTS = 2,
  parameter int    OUT_REG = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  output logic [N_PORTS-1:0]        req_ready,
  output logic [N_PORTS-1:0]        rsp_valid,
  output logic [N_PORTS*DATA_W-1:0] rsp_data
);

  `include "iob_rom_arb.vh"

  localparam int DEPTH = 2 ** ADDR_W;

  logic [N_PORTS-1:0] gnt;
  logic               accept;
  logic [PTR_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  sel_addr;

  iob_rr_arb #(
    .N(N_PORTS)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  // Encode the one-hot grant and select the winning address.
  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PTR_W'(i);
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // ROM contents are never reset.
  logic [DATA_W-1:0] rom [DEPTH];
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_data <= rom[sel_addr];
    end
  end

  // Stage 1 tracks which port owns the data now sitting in rd_data.
  logic             s1_valid;
  logic [PTR_W-1:0] s1_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_idx <= gnt_idx;
      end
    end
  end

  logic             fin_valid;
  logic [PTR_W-1:0] fin_idx;
  logic [DATA_W-1:0] fin_data;

  generate
    if (LAT == 2) begin : g_out_reg
      logic              s2_valid;
      logic [PTR_W-1:0]  s2_idx;
      logic [DATA_W-1:0] s2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_idx   <= '0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_idx  <= s1_idx;
            s2_data <= rd_data;
          end
        end
      end

      assign fin_valid = s2_valid;
      assign fin_idx   = s2_idx;
      assign fin_data  = s2_data;
    end else begin : g_no_out_reg
      assign fin_valid = s1_valid;
      assign fin_idx   = s1_idx;
      assign fin_data  = rd_data;
    end
  endgenerate

  // Per-port demux. New data is passed straight through during the pulse and
  // captured into the hold register at the end of it, so rsp_data updates in
  // the same cycle as rsp_valid and stays put until the port's next response.
  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_port
      logic [DATA_W-1:0] hold_reg;

      assign rsp_valid[gi] = fin_valid && (fin_idx == PTR_W'(gi));
      assign rsp_data[gi*DATA_W +: DATA_W] = rsp_valid[gi] ? fin_data : hold_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_reg <= '0;
        end else if (rsp_valid[gi]) begin
          hold_reg <= fin_data;
        end
      end
    end
  endgenerate

endmodule
